cond_issue_ctrl: RTL and testbench
==================================

// Module: cond_issue_ctrl
// PURPOSE
//  Issue controller between decode and execute. Holds one instruction, owns the CPSR and
//  evaluates the instruction's cond field [31:28] against the CPSR. Stalls conditional
//  instructions while flag-setting instructions are in flight.
//  Emits each instruction to execute with an exec/squash qualifier and counts squashes.
// PARAMETERS
//  MAX_PEND  4  max in-flight flag-setting instructions; pend counter width = clog2(MAX_PEND+1)
//  CNT_W     8  width of squash counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      synchronous reset, active-high
//  in_valid       in   1      decode offers in_inst
//  in_ready       out  1      controller accepts this cycle
//  in_inst        in   32     ARM instruction word
//  in_sets_flags  in   1      instruction writes NZCV (S bit / compare)
//  out_valid      out  1      out_inst/out_exec valid to execute
//  out_ready      in   1      execute accepts
//  out_inst       out  32     held instruction
//  out_exec       out  1      1 = condition passed, execute; 0 = squash (treat as NOP)
//  flag_we        in   1      writeback of NZCV from a previously issued flag-setter
//  flag_nzcv      in   4      {N,Z,C,V} written on flag_we
//  cpsr           out  32     architectural CPSR; N=31 Z=30 C=29 V=28
//  squash_cnt     out  CNT_W  issued instructions with out_exec=0, saturating
// BEHAVIOUR
//  Reset: state=EMPTY, out_valid=0, out_inst=0, out_exec=0, in_ready=1, pend=0,
//    cpsr=32'h0000_00D3, squash_cnt=0. Reset mid-operation drops the held instruction.
//  FSM (held instruction register, one entry):
//    EMPTY: in_ready=1; in_valid -> latch in_inst/in_sets_flags, go HELD.
//    HELD: issuable = (cond==AL) || (pend==0); additionally stall if in_sets_flags
//      latched and pend==MAX_PEND. issuable -> ISSUE, else stay HELD.
//    ISSUE: out_valid=1. out_ready=0 -> hold, out_inst/out_exec stable.
//      out_ready=1 -> handshake; in_ready=1 same cycle; in_valid -> load next, go HELD,
//      else EMPTY (back-to-back issue: one instruction per 2 cycles minimum).
//  Latency: in handshake -> out_valid = 2 cycles when not stalled.
//  Condition eval: identical table to the team's cond decoder (EQ..LE, AL=1,
//    NV 4'b1111 = 0), using cpsr registered value at the HELD->ISSUE edge; out_exec
//    is registered, never changes while ISSUE holds.
//  pend: +1 on handshake with latched sets_flags && out_exec; -1 on flag_we; both same
//    cycle -> unchanged. flag_we with pend==0: CPSR updated, pend stays 0 (no underflow).
//    Squashed flag-setters do not increment pend.
//  cpsr[31:28] <= flag_nzcv on flag_we; bits [27:0] never written by this block.
//  squash_cnt +1 on handshake with out_exec=0; saturates at all-ones.
// CONFIGURATION
//  COND_ISSUE_BYPASS_EN defined: in HELD, flag_we counts as a decrement for the
//    issuable check and flag_nzcv forwards into the condition eval in the same cycle;
//    a stalled instruction reaches ISSUE on the edge of the flag_we cycle.
//  Not defined: issuable/eval use registered pend/cpsr only; release occurs one
//    cycle after the flag_we cycle.
// TESTING
//  Reset then 1 inst 0xE0811002 (AL ADD), out_ready=1 -> out_valid 2 cyc later, out_exec=1
//  cpsr Z=1, issue 0x0A000000 (BEQ) -> out_exec=1; 0x1A000000 (BNE) -> out_exec=0, squash_cnt=1
//  Issue 0xE1500001 (CMP, sets_flags) -> pend=1; next 0x0A000000 stalls in HELD until
//    flag_we nzcv=4'b0100 -> issues out_exec=1 (1 cycle earlier with COND_ISSUE_BYPASS_EN)
//  out_ready=0 for 5 cycles during ISSUE -> out_inst/out_exec stable, in_ready=0
//  flag_we and flag-setter handshake same cycle -> pend unchanged; flag_we at pend=0 -> pend 0
//  rst asserted while HELD stalled -> next cycle out_valid=0, pend=0, cpsr=32'h0000_00D3

Source files
------------

// File: rtl/cond_issue_if.sv
// Decode/execute handshake, flag writeback and status bundle for cond_issue_ctrl.
// The controller connects through the slave modport; the driver side uses master.
interface cond_issue_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic             in_sets_flags;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_exec;
  logic             flag_we;
  logic [3:0]       flag_nzcv;
  logic [31:0]      cpsr;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output in_valid, in_inst, in_sets_flags, out_ready, flag_we, flag_nzcv,
    input  in_ready, out_valid, out_inst, out_exec, cpsr, squash_cnt
  );

  modport slave (
    input  in_valid, in_inst, in_sets_flags, out_ready, flag_we, flag_nzcv,
    output in_ready, out_valid, out_inst, out_exec, cpsr, squash_cnt
  );
endinterface

// File: rtl/cond_issue_ctrl.sv
// One-entry issue stage: owns the CPSR, evaluates ARM cond codes and stalls on pending flag writers.
// Optional COND_ISSUE_BYPASS_EN forwards a same-cycle flag writeback into the HELD issue decision.
module cond_issue_ctrl #(
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  cond_issue_if.slave bus
);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0]    PEND_MAX = PW'(MAX_PEND);
  localparam logic [PW-1:0]    PEND_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [27:0]      CPSR_LOW = 28'h00000D3;

  typedef enum logic [1:0] {EMPTY, HELD, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic             sf_q, sf_d;
  logic             exec_q, exec_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic [CNT_W-1:0] squash_q, squash_d;

  logic             in_ready_c, out_valid_c, hs_c, issuable_c, pend_inc_c, pend_dec_c;
  logic [PW-1:0]    eff_pend_c;
  logic [3:0]       eff_nzcv_c;

  // Odd cond codes are the complement of the even code below them; AL/NV fall out of the same rule.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  always_comb begin
`ifdef COND_ISSUE_BYPASS_EN
    eff_pend_c = (bus.flag_we && pend_q != '0) ? pend_q - PEND_ONE : pend_q;
    eff_nzcv_c = bus.flag_we ? bus.flag_nzcv : nzcv_q;
`else
    eff_pend_c = pend_q;
    eff_nzcv_c = nzcv_q;
`endif
    issuable_c = ((inst_q[31:28] == 4'hE) || (eff_pend_c == '0)) &&
                 !(sf_q && (eff_pend_c == PEND_MAX));
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    sf_d        = sf_q;
    exec_d      = exec_q;
    pend_d      = pend_q;
    nzcv_d      = nzcv_q;
    squash_d    = squash_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    hs_c        = 1'b0;

    case (state_q)
      EMPTY: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          inst_d  = bus.in_inst;
          sf_d    = bus.in_sets_flags;
          state_d = HELD;
        end
      end
      HELD: begin
        if (issuable_c) begin
          exec_d  = cond_pass(inst_q[31:28], eff_nzcv_c);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          hs_c       = 1'b1;
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            inst_d  = bus.in_inst;
            sf_d    = bus.in_sets_flags;
            state_d = HELD;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // A flag writeback with nothing pending still updates NZCV but never underflows the counter.
    pend_inc_c = hs_c && sf_q && exec_q;
    pend_dec_c = bus.flag_we && (pend_q != '0);
    if (pend_inc_c && !pend_dec_c) begin
      pend_d = pend_q + PEND_ONE;
    end else if (pend_dec_c && !pend_inc_c) begin
      pend_d = pend_q - PEND_ONE;
    end

    if (bus.flag_we) begin
      nzcv_d = bus.flag_nzcv;
    end

    if (hs_c && !exec_q && (squash_q != '1)) begin
      squash_d = squash_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      inst_q   <= '0;
      sf_q     <= 1'b0;
      exec_q   <= 1'b0;
      pend_q   <= '0;
      nzcv_q   <= 4'h0;
      squash_q <= '0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      sf_q     <= sf_d;
      exec_q   <= exec_d;
      pend_q   <= pend_d;
      nzcv_q   <= nzcv_d;
      squash_q <= squash_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_inst   = inst_q;
  assign bus.out_exec   = exec_q;
  assign bus.cpsr       = {nzcv_q, CPSR_LOW};
  assign bus.squash_cnt = squash_q;
endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Self-checking bench for cond_issue_ctrl: directed scenarios plus a randomized run
// against a transaction-level model (flags, pending count, in-order queue).
module tb_cond_issue_ctrl;
  localparam int MAX_PEND = 4;
  localparam int CNT_W    = 8;
`ifdef COND_ISSUE_BYPASS_EN
  localparam int REL = 1;
`else
  localparam int REL = 2;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_sq;
  logic [3:0] cur_nzcv;

  cond_issue_if #(.CNT_W(CNT_W)) bus ();

  cond_issue_ctrl #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Phase convention: tasks start and end 1 time unit after a rising edge.
  task automatic do_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flag_we = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_nzcv = 4'h0;
    exp_sq = 0;
  endtask

  task automatic pulse_flags(input logic [3:0] nzcv);
    bus.flag_we = 1'b1;
    bus.flag_nzcv = nzcv;
    cur_nzcv = nzcv;
    @(posedge clk); #1;
    bus.flag_we = 1'b0;
  endtask

  task automatic offer(input logic [31:0] inst, input logic sf);
    int g;
    bus.in_valid = 1'b1;
    bus.in_inst = inst;
    bus.in_sets_flags = sf;
    #1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #2;
      g++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic sf,
                      output logic ex, output logic [31:0] oi, output int lat);
    bus.out_ready = 1'b1;
    offer(inst, sf);
    lat = 1;
    #1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #2;
      lat++;
    end
    ex = bus.out_exec;
    oi = bus.out_inst;
    @(posedge clk); #1;
  endtask

  task automatic wait_release(input logic [3:0] nzcv, output int n,
                              output logic ex, output logic [31:0] oi);
    bus.flag_we = 1'b1;
    bus.flag_nzcv = nzcv;
    cur_nzcv = nzcv;
    #1;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk); #1;
      bus.flag_we = 1'b0;
      #1;
      n++;
    end
    bus.flag_we = 1'b0;
    ex = bus.out_exec;
    oi = bus.out_inst;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_inst: got %h want 0", bus.out_inst); end
    checks++; if (bus.out_exec !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_exec: got %0b want 0", bus.out_exec); end
    checks++; if (bus.cpsr !== 32'h0000_00D3) begin errors++; $display("[TB] FAIL reset_cpsr: got %h want 000000d3", bus.cpsr); end
    checks++; if (bus.squash_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_squash: got %0d want 0", bus.squash_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    logic ex; logic [31:0] oi; int lat;
    send(32'hE0811002, 1'b0, ex, oi, lat);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL latency_al_add: got %0d want 2", lat); end
    checks++; if (ex !== 1'b1) begin errors++; $display("[TB] FAIL exec_al_add: got %0b want 1", ex); end
    checks++; if (oi !== 32'hE0811002) begin errors++; $display("[TB] FAIL inst_al_add: got %h want e0811002", oi); end
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_issue_idle: got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_cond_eval;
    logic ex; logic [31:0] oi; int lat;
    logic [3:0] c, nz;
    pulse_flags(4'b0100);
    #1;
    checks++; if (bus.cpsr !== 32'h4000_00D3) begin errors++; $display("[TB] FAIL cpsr_z_set: got %h want 400000d3", bus.cpsr); end
    @(posedge clk); #1;
    send(32'h0A000000, 1'b0, ex, oi, lat);
    checks++; if (ex !== 1'b1) begin errors++; $display("[TB] FAIL beq_z1: got %0b want 1", ex); end
    send(32'h1A000000, 1'b0, ex, oi, lat);
    exp_sq++;
    checks++; if (ex !== 1'b0) begin errors++; $display("[TB] FAIL bne_z1: got %0b want 0", ex); end
    checks++; if (bus.squash_cnt !== CNT_W'(exp_sq)) begin errors++; $display("[TB] FAIL squash_after_bne: got %0d want %0d", bus.squash_cnt, exp_sq); end
    for (int i = 0; i < 10; i++) begin
      nz = 4'($urandom);
      c = 4'($urandom_range(0, 15));
      pulse_flags(nz);
      send({c, 28'h1234567}, 1'b0, ex, oi, lat);
      if (!cond_ok(c, nz)) exp_sq++;
      checks++; if (ex !== cond_ok(c, nz)) begin errors++; $display("[TB] FAIL cond_rand: cond=%h nzcv=%b got %0b want %0b", c, nz, ex, cond_ok(c, nz)); end
    end
    checks++; if (bus.squash_cnt !== CNT_W'(exp_sq)) begin errors++; $display("[TB] FAIL squash_cond_eval: got %0d want %0d", bus.squash_cnt, exp_sq); end
  endtask

  task automatic test_stall;
    logic ex; logic [31:0] oi; int lat, n;
    pulse_flags(4'b0000);
    send(32'hE1500001, 1'b1, ex, oi, lat);
    checks++; if (ex !== 1'b1 || lat !== 2) begin errors++; $display("[TB] FAIL cmp_issue: got exec=%0b lat=%0d want 1/2", ex, lat); end
    bus.out_ready = 1'b0;
    offer(32'h0A000000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_beq_c%0d: got out_valid=%0b want 0", k, bus.out_valid); end
      @(posedge clk); #1;
    end
    wait_release(4'b0100, n, ex, oi);
    checks++; if (n !== REL) begin errors++; $display("[TB] FAIL stall_release_cycles: got %0d want %0d", n, REL); end
    checks++; if (ex !== 1'b1 || oi !== 32'h0A000000) begin errors++; $display("[TB] FAIL stall_release_exec: got exec=%0b inst=%h want 1/0a000000", ex, oi); end
    #1;
    checks++; if (bus.cpsr !== 32'h4000_00D3) begin errors++; $display("[TB] FAIL cpsr_after_flag_we: got %h want 400000d3", bus.cpsr); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic exp_b;
    exp_b = cond_ok(4'h1, cur_nzcv);
    bus.out_ready = 1'b0;
    offer(32'hE0811002, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_inst = 32'h1A000000;
    bus.in_sets_flags = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'hE0811002 || bus.out_exec !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_c%0d: got valid=%0b inst=%h exec=%0b ready=%0b want 1/e0811002/1/0", k, bus.out_valid, bus.out_inst, bus.out_exec, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_on_handshake: got %0b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got %0b want 0", bus.out_valid); end
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h1A000000 || bus.out_exec !== exp_b) begin
      errors++; $display("[TB] FAIL b2b_second: got valid=%0b inst=%h exec=%0b want 1/1a000000/%0b", bus.out_valid, bus.out_inst, bus.out_exec, exp_b);
    end
    if (!exp_b) exp_sq++;
    @(posedge clk); #1;
  endtask

  task automatic test_max_pend;
    logic ex; logic [31:0] oi; int lat, n;
    for (int i = 0; i < MAX_PEND; i++) send(32'hE1500001, 1'b1, ex, oi, lat);
    send(32'hE0811002, 1'b0, ex, oi, lat);
    checks++; if (lat !== 2 || ex !== 1'b1) begin errors++; $display("[TB] FAIL al_at_max_pend: got lat=%0d exec=%0b want 2/1", lat, ex); end
    bus.out_ready = 1'b0;
    offer(32'hE1500001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL setter_stall_max_c%0d: got %0b want 0", k, bus.out_valid); end
      @(posedge clk); #1;
    end
    wait_release(4'b0000, n, ex, oi);
    checks++; if (n !== REL || ex !== 1'b1) begin errors++; $display("[TB] FAIL max_pend_release: got n=%0d exec=%0b want %0d/1", n, ex, REL); end
    for (int i = 0; i < MAX_PEND; i++) pulse_flags(4'b0000);
  endtask

  task automatic test_same_cycle;
    logic ex; logic [31:0] oi; int lat, n;
    send(32'hE1500001, 1'b1, ex, oi, lat);
    bus.out_ready = 1'b0;
    offer(32'hE1500001, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.flag_we = 1'b1;
    bus.flag_nzcv = 4'b0100;
    cur_nzcv = 4'b0100;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_issue: got %0b want 1", bus.out_valid); end
    @(posedge clk); #1;
    bus.flag_we = 1'b0;
    bus.out_ready = 1'b0;
    offer(32'h0A000000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pend_kept_c%0d: got %0b want 0", k, bus.out_valid); end
      @(posedge clk); #1;
    end
    wait_release(4'b0100, n, ex, oi);
    checks++; if (n !== REL || ex !== 1'b1) begin errors++; $display("[TB] FAIL pend_one_release: got n=%0d exec=%0b want %0d/1", n, ex, REL); end
    pulse_flags(4'b0000);
    #1;
    checks++; if (bus.cpsr !== 32'h0000_00D3) begin errors++; $display("[TB] FAIL cpsr_orphan_we: got %h want 000000d3", bus.cpsr); end
    @(posedge clk); #1;
    send(32'h1A000000, 1'b0, ex, oi, lat);
    checks++; if (lat !== 2 || ex !== 1'b1) begin errors++; $display("[TB] FAIL no_underflow: got lat=%0d exec=%0b want 2/1", lat, ex); end
  endtask

  task automatic test_reset_midop;
    logic ex; logic [31:0] oi; int lat;
    send(32'hE1500001, 1'b1, ex, oi, lat);
    pulse_flags(4'b0100);
    send(32'hE1500001, 1'b1, ex, oi, lat);
    offer(32'h0A000000, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midop_stalled: got %0b want 0", bus.out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_nzcv = 4'h0;
    exp_sq = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midop_reset_hs: got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.cpsr !== 32'h0000_00D3) begin errors++; $display("[TB] FAIL midop_reset_cpsr: got %h want 000000d3", bus.cpsr); end
    @(posedge clk); #1;
    send(32'h0A000000, 1'b0, ex, oi, lat);
    exp_sq++;
    checks++; if (lat !== 2 || ex !== 1'b0) begin errors++; $display("[TB] FAIL midop_pend_cleared: got lat=%0d exec=%0b want 2/0", lat, ex); end
    checks++; if (bus.squash_cnt !== CNT_W'(exp_sq)) begin errors++; $display("[TB] FAIL midop_squash: got %0d want %0d", bus.squash_cnt, exp_sq); end
  endtask

  task automatic test_random;
    logic [32:0] q[$];
    logic [32:0] e;
    logic [3:0]  mn, c;
    int mpend, idle;
    logic acc, hs, ex, inc;
    do_reset();
    mn = 4'h0; mpend = 0; idle = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      c = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15));
      bus.in_valid = ($urandom_range(0, 9) < 6);
      bus.in_inst = {c, 28'($urandom)};
      bus.in_sets_flags = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flag_we = (mpend > 0) && ($urandom_range(0, 3) == 0);
      bus.flag_nzcv = 4'($urandom);
      #1;
      checks++; if (bus.cpsr !== {mn, 28'h00000D3}) begin errors++; $display("[TB] FAIL rnd_cpsr@%0d: got %h want %h", cyc, bus.cpsr, {mn, 28'h00000D3}); end
      checks++; if (bus.squash_cnt !== CNT_W'(exp_sq)) begin errors++; $display("[TB] FAIL rnd_squash@%0d: got %0d want %0d", cyc, bus.squash_cnt, exp_sq); end
      acc = bus.in_valid && bus.in_ready;
      hs = bus.out_valid && bus.out_ready;
      inc = 1'b0;
      if (bus.out_valid) begin
        checks++; if (q.size() == 0) begin errors++; $display("[TB] FAIL rnd_spurious_valid@%0d: got out_valid=1 want 0 (nothing held)", cyc); end
      end
      if (hs && q.size() > 0) begin
        e = q.pop_front();
        ex = cond_ok(e[31:28], mn);
        checks++; if (bus.out_inst !== e[31:0]) begin errors++; $display("[TB] FAIL rnd_inst@%0d: got %h want %h", cyc, bus.out_inst, e[31:0]); end
        checks++; if (bus.out_exec !== ex) begin errors++; $display("[TB] FAIL rnd_exec@%0d: got %0b want %0b", cyc, bus.out_exec, ex); end
        if (e[31:28] != 4'hE) begin
          checks++; if (mpend != 0) begin errors++; $display("[TB] FAIL rnd_cond_while_pending@%0d: got pend=%0d want 0", cyc, mpend); end
        end
        if (e[32] && ex) begin
          inc = 1'b1;
          checks++; if (mpend >= MAX_PEND) begin errors++; $display("[TB] FAIL rnd_pend_overflow@%0d: got pend=%0d want <%0d", cyc, mpend, MAX_PEND); end
        end
        if (!ex && exp_sq < 255) exp_sq++;
        idle = 0;
      end
      if (acc) begin
        checks++; if (q.size() != 0) begin errors++; $display("[TB] FAIL rnd_accept_full@%0d: got accept with %0d held want none", cyc, q.size()); end
        q.push_back({bus.in_sets_flags, bus.in_inst});
      end
      if (q.size() > 0 && !hs) idle++;
      if (idle > 60) begin
        checks++; errors++;
        $display("[TB] FAIL rnd_liveness@%0d: got no issue for %0d cycles want <=60", cyc, idle);
        break;
      end
      if (bus.flag_we) begin mpend--; mn = bus.flag_nzcv; end
      if (inc) mpend++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flag_we = 1'b0;
  endtask

  task automatic test_saturation;
    logic ex; logic [31:0] oi; int lat;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send(32'hF0000000, 1'b0, ex, oi, lat);
      if (exp_sq < 255) exp_sq++;
    end
    checks++; if (ex !== 1'b0) begin errors++; $display("[TB] FAIL nv_exec: got %0b want 0", ex); end
    checks++; if (bus.squash_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL squash_saturate: got %0d want 255", bus.squash_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_sq = 0;
    cur_nzcv = 4'h0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_inst = 32'h0;
    bus.in_sets_flags = 1'b0;
    bus.out_ready = 1'b1;
    bus.flag_we = 1'b0;
    bus.flag_nzcv = 4'h0;
    test_reset();
    test_latency();
    test_cond_eval();
    test_stall();
    test_backpressure();
    test_max_pend();
    test_same_cycle();
    test_reset_midop();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
